// File: rtl/bin2bcd_pkg.sv
// Shared types and default sizing for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;
    localparam int COUNT_W    = $clog2(DEF_WIDTH);

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-packed-BCD converter with start/busy/done handshake.
// Optional macro BIN2BCD_AUTO_EN: convert automatically whenever value changes (start ignored).
import bin2bcd_pkg::*;

module bin2bcd_seq #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH);
    localparam int BW = 4 * DIGITS;

    state_t          state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [BW-1:0]   scratch_reg, scratch_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [BW-1:0]   bcd_reg, bcd_next;
    logic            done_reg, done_next;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   shifted;
    logic            launch;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (scratch_reg[gi*4 +: 4]),
                .dout (adj[gi*4 +: 4])
            );
        end
    endgenerate

    // The MSB of the binary operand enters digit 0 as the whole vector shifts left.
    assign shifted = {adj[BW-2:0], shift_reg[WIDTH-1]};

`ifdef BIN2BCD_AUTO_EN
    logic [WIDTH-1:0] last_value_reg;
    logic             unused_start;

    assign unused_start = start;
    assign launch       = (value != last_value_reg);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            last_value_reg <= '0;
        end else if (state_reg == IDLE && launch) begin
            last_value_reg <= value;
        end
    end
`else
    assign launch = start;
`endif

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        scratch_next = scratch_reg;
        count_next   = count_reg;
        bcd_next     = bcd_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (launch) begin
                    shift_next   = value;
                    scratch_next = '0;
                    count_next   = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_next = shifted;
                shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
                count_next   = count_reg + CW'(1);
                if (count_reg == CW'(WIDTH - 1)) begin
                    bcd_next   = shifted;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            scratch_reg <= '0;
            count_reg   <= '0;
            bcd_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            scratch_reg <= scratch_next;
            count_reg   <= count_next;
            bcd_reg     <= bcd_next;
            done_reg    <= done_next;
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, random values against a decimal model, handshake corners.
module tb_bin2bcd_seq;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic [15:0] value  = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    bin2bcd_seq dut (
        .clk_in (clk_in),
        .reset  (reset),
        .value  (value),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
    );

    typedef struct {
        logic [15:0] v;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[6];

    // Decimal digits of v, digit 0 in the low nibble.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // Pulse start for one cycle, then wait (bounded) for done. lat counts edges from the start edge.
    task automatic do_conv(input logic [15:0] v, output logic [19:0] res, output int lat, output int bcnt);
        @(negedge clk_in);
        value = v;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk_in);
            lat++;
        end
        res = bcd;
    endtask

    initial begin
        logic [19:0] res;
        int lat, bcnt, ndone, last_c, gap_bad;
        logic [15:0] rv;

        vecs[0] = '{16'd0,     20'h00000};
        vecs[1] = '{16'd6765,  20'h06765};
        vecs[2] = '{16'hFFFF,  20'h65535};
        vecs[3] = '{16'd9,     20'h00009};
        vecs[4] = '{16'd10000, 20'h10000};
        vecs[5] = '{16'd4999,  20'h04999};

        repeat (3) @(negedge clk_in);
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_conv(vecs[i].v, res, lat, bcnt);
            check($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].exp));
            if (i == 0) begin
                check("latency", 32'(lat), 32'd17);
                check("busy_cycles", 32'(bcnt), 32'd16);
                check("done_busy_low", 32'(busy), 32'h0);
                @(negedge clk_in);
                check("done_one_cycle", 32'(done), 32'h0);
            end
        end

        for (int i = 0; i < 20; i++) begin
            rv = 16'($urandom);
            do_conv(rv, res, lat, bcnt);
            check($sformatf("rand%0d_%0d", i, rv), 32'(res), 32'(ref_bcd(32'(rv))));
        end

        // Continuous start: done every 17 cycles, nothing extra.
        @(negedge clk_in);
        value   = 16'd233;
        start   = 1'b1;
        ndone   = 0;
        last_c  = -1;
        gap_bad = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk_in);
            if (done) begin
                ndone++;
                if (last_c >= 0 && c - last_c != 17) gap_bad++;
                last_c = c;
                check("cont_bcd", 32'(bcd), 32'h00233);
            end
        end
        start = 1'b0;
        check("cont_done_count", 32'(ndone), 32'd4);
        check("cont_gap_errors", 32'(gap_bad), 32'd0);
        repeat (20) @(negedge clk_in);

        // Start pulses during SHIFT are ignored.
        value = 16'd100;
        start = 1'b1;
        @(negedge clk_in);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            start = (c == 3 || c == 9);
            @(negedge clk_in);
            if (done) ndone++;
        end
        start = 1'b0;
        check("ignored_start_dones", 32'(ndone), 32'd1);
        check("ignored_start_bcd", 32'(bcd), 32'h00100);

        // Operand change mid-conversion has no effect.
        value = 16'd55;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (4) @(negedge clk_in);
        value = 16'd89;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk_in);
            lat++;
        end
        check("value_change_bcd", 32'(bcd), 32'h00055);

        // Reset in the middle of a conversion.
        @(negedge clk_in);
        value = 16'd9999;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (7) @(negedge clk_in);
        check("pre_reset_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("midreset_bcd", 32'(bcd), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_done", 32'(done), 32'h0);
        @(negedge clk_in);
        reset = 1'b1;
        do_conv(16'd1234, res, lat, bcnt);
        check("post_reset_bcd", 32'(res), 32'h01234);
        check("post_reset_latency", 32'(lat), 32'd17);

        // No start, no conversion.
        value = 16'd777;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (done || busy) ndone++;
        end
        check("idle_no_activity", 32'(ndone), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble converter that turns the 16-bit register value driven out of the data path (e.g. r5) into packed BCD digits for the seven-segment display stage. It sits directly downstream of the datapath/FSM pair and upstream of the hex-digit decoders, so the boards show decimal Fibonacci values instead of hex. It runs on the fast board clock, independent of the divided core clock, and uses a start/busy/done handshake.

## Interface
- WIDTH, 16, binary input width
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1
- clk_in  input  1  board clock (50 MHz)
- reset  input  1  asynchronous, active-low reset
- value  input  WIDTH  unsigned binary operand
- start  input  1  conversion request, sampled only in IDLE
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse, bcd updated this cycle
- bcd  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; holds last result

## Operation
- States: IDLE, SHIFT.
- IDLE: on start=1 at edge E, latch value into shift register, clear scratch digits, clear count, go to SHIFT.
- SHIFT: each edge, every scratch digit >= 5 gets +3, then {scratch, shift} shifts left by one; count increments.
- On the edge where count == WIDTH-1 (the WIDTH-th shift), the adjusted-and-shifted scratch is written to bcd, done <= 1, state <= IDLE.
- value is sampled once at start; changes during SHIFT have no effect.
- start while busy: ignored, not queued.
- start during the done cycle: accepted (state is IDLE).
- Arithmetic: digit adjust is 4-bit, no carry between digits except through the shift; largest input 65535 -> bcd 20'h65535.
- Reset (any time, including mid-conversion): state IDLE, bcd = 0, busy = 0, done = 0, count = 0, scratch cleared.

## Timing
- start sampled at edge E; busy high from E+1 through E+WIDTH (16 cycles for WIDTH=16).
- Final shift at edge E+WIDTH+1: bcd updated, done high for exactly that one cycle, busy low in the same cycle.
- Latency start-edge to done: WIDTH+1 edges (17 by default); back-to-back throughput one result per WIDTH+1 cycles.
- bcd is registered; it never shows partial results.

## Configuration
- BIN2BCD_AUTO_EN defined: start port ignored; in IDLE the block compares value with an internal last_value register (reset 0) and, when they differ, launches a conversion and latches last_value in the same edge. The display tracks the datapath with no external control.
- BIN2BCD_AUTO_EN undefined: conversions happen only on start; no last_value register is built.

## Structure
- Package bin2bcd_pkg: state enum (IDLE, SHIFT), default WIDTH/DIGITS constants, count width as $clog2(WIDTH).
- Sub-module bcd_digit_adj: combinational 4-bit "add 3 if >= 5", instantiated DIGITS times by a generate loop.
- Top-level display wiring feeds bcd digits to the existing hex7 decoding per HEX digit.

## Test plan
- Reset mid-SHIFT (assert reset at 8th shift) -> bcd=0, busy=0, done=0 immediately; next start converts cleanly.
- value=16'd0, start one cycle -> done after 17 edges, bcd=20'h00000, busy high exactly 16 cycles.
- value=16'd6765 (Fib 20) -> bcd=20'h06765; value=16'hFFFF -> bcd=20'h65535.
- start asserted continuously with value=16'd233 -> done pulses every 17 cycles, bcd=20'h00233; start pulses inside SHIFT produce no extra done.
- value changed from 55 to 89 at cycle 5 of SHIFT -> result is 20'h00055, not 89.
- With BIN2BCD_AUTO_EN: value steps 0->1->1->2 (each held 40 cycles) -> exactly two done pulses, bcd ends at 20'h00002; without macro and start=0 -> no done.
